pwm_fade_ctrl: RTL and testbench

Upstream control stage for the `pwm` block. It generates the `step` pacing pulse and a time-varying `duty` word so an attached PWM output "breathes": it ramps up, holds, ramps down and holds. Its `step`, `duty` and `busy` outputs connect directly to the PWM's `step`, `duty` and `ena` inputs. Fade shape is set by run-time inputs: prescale, increment, hold length and loop.

---
 rtl/pwm_fade_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: drives a PWM's step/duty/ena so its output ramps up, holds,
// ramps down and holds ("breathing"), with run-time prescale, increment,
// dwell length and loop control.
module pwm_fade_ctrl #(
    parameter int N  = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [PW-1:0] prescale,
    input  logic [N-1:0]  inc,
    input  logic [7:0]    hold,
    output logic          step,
    output logic [N-1:0]  duty,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_t;

    localparam logic [N-1:0] MAX = '1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state, state_nx;
    logic [PW-1:0]  pcnt, pcnt_nx;
    logic [7:0]     hcnt, hcnt_nx;
    logic [N-1:0]   duty_nx;
    logic           done_nx;
    logic           tick;
    logic [N-1:0]   incx;
    logic [N:0]     up_sum;
    logic signed [N:0] dn_diff;

    // >= rather than == so that lowering prescale mid-count ticks at once
    assign tick    = ena && (pcnt >= prescale);
    assign incx    = (inc == '0) ? ONE : inc;
    assign up_sum  = {1'b0, duty} + {1'b0, incx};
    assign dn_diff = $signed({1'b0, duty}) - $signed({1'b0, incx});

    // Next-state, prescaler, dwell counter and saturating duty arithmetic
    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        hcnt_nx  = hcnt;
        duty_nx  = duty;
        done_nx  = 1'b0;

        if (ena) begin
            pcnt_nx = tick ? '0 : pcnt + 1'b1;
        end

        if (stop) begin
            state_nx = IDLE;
            duty_nx  = '0;
            hcnt_nx  = '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    duty_nx = '0;
                    if (start) begin
                        state_nx = UP;
                        pcnt_nx  = '0;
                    end
                end
                UP: begin
                    if (tick) begin
                        if (up_sum >= {1'b0, MAX}) begin
                            duty_nx  = MAX;
                            state_nx = HOLD_HI;
                            hcnt_nx  = '0;
                        end else begin
                            duty_nx = up_sum[N-1:0];
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) begin
                        if (hcnt == hold) begin
                            state_nx = DOWN;
                        end else begin
                            hcnt_nx = hcnt + 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (tick) begin
                        if (dn_diff <= 0) begin
                            duty_nx  = '0;
                            state_nx = HOLD_LO;
                            hcnt_nx  = '0;
                        end else begin
                            duty_nx = dn_diff[N-1:0];
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) begin
                        if (hcnt == hold) begin
                            if (loop) begin
                                state_nx = UP;
                            end else begin
                                state_nx = IDLE;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            hcnt_nx = hcnt + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and registered outputs; busy is taken from the next state so it
    // moves on the same edge as the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            hcnt  <= '0;
            duty  <= '0;
            step  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            hcnt  <= hcnt_nx;
            duty  <= duty_nx;
            step  <= tick;
            busy  <= (state_nx != IDLE);
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: stimulus pushes the expected per-tick
// duty/busy/done/spacing into a queue; a monitor pops one entry per step.
module tb_pwm_fade_ctrl;

    localparam int N  = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst, ena, start, stop, loop;
    logic [PW-1:0] prescale;
    logic [N-1:0]  inc;
    logic [7:0]    hold;
    logic          step, busy, done;
    logic [N-1:0]  duty;

    typedef struct {
        int duty;
        bit busy;
        bit done;
        int gap;
    } item_t;

    item_t exp_q[$];
    item_t mon_it;
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    last_evt = 0;
    bit    busy_q = 1'b0;
    bit    mon_on = 1'b0;

    pwm_fade_ctrl #(.N(N), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .prescale (prescale),
        .inc      (inc),
        .hold     (hold),
        .step     (step),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: a fade is a list of tick values built from the
    // ramp/dwell rules with plain saturating integer arithmetic.
    task automatic push_item(input int d, input bit b, input bit dn, input int g);
        item_t it;
        it.duty = d;
        it.busy = b;
        it.done = dn;
        it.gap  = g;
        exp_q.push_back(it);
    endtask

    task automatic push_fade(input int incv, input int holdv, input int cycles,
                             input int gap, input int sp_idx, input int sp_gap);
        int incx;
        int d;
        int idx;
        bit last;
        incx = (incv == 0) ? 1 : incv;
        idx  = 0;
        for (int c = 0; c < cycles; c++) begin
            d = 0;
            while (d < 255) begin
                d = d + incx;
                if (d > 255) d = 255;
                push_item(d, 1'b1, 1'b0, (idx == sp_idx) ? sp_gap : gap);
                idx++;
            end
            for (int h = 0; h <= holdv; h++) begin
                push_item(255, 1'b1, 1'b0, (idx == sp_idx) ? sp_gap : gap);
                idx++;
            end
            while (d > 0) begin
                d = d - incx;
                if (d < 0) d = 0;
                push_item(d, 1'b1, 1'b0, (idx == sp_idx) ? sp_gap : gap);
                idx++;
            end
            for (int h = 0; h <= holdv; h++) begin
                last = (c == cycles - 1) && (h == holdv);
                push_item(0, !last, last, (idx == sp_idx) ? sp_gap : gap);
                idx++;
            end
        end
    endtask

    task automatic trim(input int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d ticks pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: one queue entry per step while a fade is in progress
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy && !busy_q) last_evt = cyc;
            if (step && busy_q) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_tick: got tick with duty %0d, expected none", duty);
                end else begin
                    mon_it = exp_q.pop_front();
                    check("tick_duty", int'(duty), mon_it.duty);
                    check("tick_busy", int'(busy), int'(mon_it.busy));
                    check("tick_done", int'(done), int'(mon_it.done));
                    if (mon_it.gap != 0) check("tick_gap", cyc - last_evt, mon_it.gap);
                end
                last_evt = cyc;
            end else if (done) begin
                check("stray_done", int'(done), 0);
            end
            if (!busy) check("idle_duty", int'(duty), 0);
            busy_q = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p;
        rst = 1'b1; ena = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        prescale = 16'd3; inc = 8'd64; hold = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_step", int'(step), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        ena = 1'b1;
        mon_on = 1'b1;

        // Single fade
        push_fade(64, 1, 1, 4, -1, 0);
        do_start();
        drain(300);
        repeat (6) @(negedge clk);

        // Loop, cleared during the third DOWN ramp
        loop = 1'b1;
        push_fade(64, 1, 3, 4, -1, 0);
        do_start();
        n = 0;
        while (exp_q.size() > 5 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("loop_reached_down", int'(exp_q.size() <= 5), 1);
        loop = 1'b0;
        drain(300);
        repeat (4) @(negedge clk);

        // inc=0 steps by 1, prescale=0 ticks every clock
        prescale = 16'd0; inc = 8'd0; hold = 8'd0;
        push_fade(0, 0, 1, 1, -1, 0);
        do_start();
        drain(1200);
        repeat (4) @(negedge clk);

        // inc=255 jumps straight to the extremes
        inc = 8'd255;
        push_fade(255, 0, 1, 1, -1, 0);
        do_start();
        drain(50);
        repeat (4) @(negedge clk);

        // Pause for 10 clocks mid-UP at duty 128
        prescale = 16'd3; inc = 8'd64; hold = 8'd1;
        push_fade(64, 1, 1, 4, 2, 14);
        do_start();
        n = 0;
        while (exp_q.size() > 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ena = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("pause_step", int'(step), 0);
            check("pause_duty", int'(duty), 128);
        end
        ena = 1'b1;
        drain(300);
        repeat (4) @(negedge clk);

        // stop during DOWN
        push_fade(64, 1, 1, 4, -1, 0);
        trim(7);
        do_start();
        drain(200);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_duty", int'(duty), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);
        repeat (8) @(negedge clk);

        // start and stop together stay IDLE
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) begin
            check("startstop_busy", int'(busy), 0);
            @(negedge clk);
        end

        // rst in HOLD_HI
        hold = 8'd3;
        push_fade(64, 3, 1, 4, -1, 0);
        trim(5);
        do_start();
        drain(200);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_step", int'(step), 0);
        check("midrst_duty", int'(duty), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Lower prescale from 20 to 5 while pcnt is 10
        prescale = 16'd20; inc = 8'd255; hold = 8'd0;
        push_fade(255, 0, 1, 6, 0, 11);
        do_start();
        repeat (10) @(negedge clk);
        prescale = 16'd5;
        drain(100);
        repeat (4) @(negedge clk);

        // Randomized one-shot fades
        for (int r = 0; r < 6; r++) begin
            p        = $urandom_range(0, 5);
            prescale = PW'(p);
            inc      = N'($urandom_range(0, 255));
            hold     = 8'($urandom_range(0, 3));
            loop     = 1'b0;
            push_fade(int'(inc), int'(hold), 1, p + 1, -1, 0);
            do_start();
            drain((520 + 8) * (p + 1) + 20);
            repeat (3) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
